// File: rtl/enstack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : enstack_pkg                                                      |
// | Purpose : Shared op encoding for the enable-stack array.                   |
// |           NOP=0, ALLEN=1, PUSHEN=2, POPEN=3, JUMPF=4.                      |
// |           Codes 5..7 have no enumerator and decode as NOP.                 |
// | Rev     : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package enstack_pkg;

  localparam int ENSTACK_OP_W = 3;

  typedef enum logic [ENSTACK_OP_W-1:0] {
    OP_NOP    = 3'd0,
    OP_ALLEN  = 3'd1,
    OP_PUSHEN = 3'd2,
    OP_POPEN  = 3'd3,
    OP_JUMPF  = 3'd4
  } enstack_op_t;

endpackage : enstack_pkg
`default_nettype wire

// File: rtl/enstack_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : enstack_lane                                                     |
// | Purpose : One lane's DEPTH-entry enable shift stack. Entry 0 is the top    |
// |           of stack and is presented on en.                                 |
// | Ports   : clk       in   clock, all state changes on posedge              |
// |           reset     in   synchronous active-low reset (stack -> all ones) |
// |           halt      in   freeze the stack while high                      |
// |           op_valid  in   op qualifier                                     |
// |           op        in   3-bit op code (enstack_op_t values)              |
// |           cond_nz   in   this lane's "d value nonzero" flag for JUMPF     |
// |           en        out  registered top-of-stack enable                   |
// | Rev     : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module enstack_lane
  import enstack_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       halt,
  input  logic       op_valid,
  input  logic [2:0] op,
  input  logic       cond_nz,
  output logic       en
);

  // Bit 0 is the top of stack, bit DEPTH-1 the bottom.
  logic [DEPTH-1:0] stack_q;
  logic [DEPTH-1:0] stack_d;

  always_comb begin
    stack_d = stack_q;
    if (op_valid && !halt) begin
      case (op)
        OP_ALLEN:  stack_d[0] = 1'b1;
        // Duplicate the top into entry 1; the bottom entry falls off.
        OP_PUSHEN: stack_d = {stack_q[DEPTH-2:0], stack_q[0]};
        // Shift up; the bottom entry keeps its value (replicated).
        OP_POPEN:  stack_d = {stack_q[DEPTH-1], stack_q[DEPTH-1:1]};
        OP_JUMPF:  if (!cond_nz) stack_d[0] = 1'b0;
        default:   stack_d = stack_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stack_q <= '1;
    end else begin
      stack_q <= stack_d;
    end
  end

  assign en = stack_q[0];

endmodule : enstack_lane
`default_nettype wire

// File: rtl/enable_stack_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : enable_stack_array                                               |
// | Purpose : NLANES enable stacks driven by a common op stream, plus a shared |
// |           push-depth counter with sticky overflow/underflow flags.         |
// | Config  : define ENSTACK_ERR_EN to build level/ovf/unf/clr_err; without    |
// |           it those outputs are tied to 0 and clr_err is ignored.           |
// | Ports   : clk       in   clock                                            |
// |           reset     in   synchronous active-low reset                     |
// |           halt      in   freezes all state (after reset) while high       |
// |           op_valid  in   op qualifier                                     |
// |           op        in   3-bit op code                                    |
// |           cond_nz   in   per-lane JUMPF condition                         |
// |           clr_err   in   clears ovf/unf                                   |
// |           en        out  per-lane top-of-stack enable                     |
// |           none_en   out  high when every en bit is 0                      |
// |           level     out  pushes outstanding (saturating 0..DEPTH)         |
// |           ovf, unf  out  sticky overflow / underflow                      |
// | Rev     : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module enable_stack_array
  import enstack_pkg::*;
#(
  parameter int NLANES = 2,
  parameter int DEPTH  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       halt,
  input  logic                       op_valid,
  input  logic [2:0]                 op,
  input  logic [NLANES-1:0]          cond_nz,
  input  logic                       clr_err,
  output logic [NLANES-1:0]          en,
  output logic                       none_en,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf,
  output logic                       unf
);

  localparam int LVL_W = $clog2(DEPTH+1);

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    enstack_lane #(
      .DEPTH (DEPTH)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .halt     (halt),
      .op_valid (op_valid),
      .op       (op),
      .cond_nz  (cond_nz[g]),
      .en       (en[g])
    );
  end

  // en is already a flop output, so this NOR carries no path from op.
  assign none_en = ~|en;

`ifdef ENSTACK_ERR_EN
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (!halt) begin
      // Clear first so that an error event in the same cycle wins.
      if (clr_err) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      if (op_valid) begin
        case (op)
          OP_PUSHEN: begin
            if (level_q == LVL_W'(DEPTH)) ovf_d = 1'b1;
            else                          level_d = level_q + LVL_W'(1);
          end
          OP_POPEN: begin
            if (level_q == '0) unf_d = 1'b1;
            else               level_d = level_q - LVL_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign level = level_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
`else
  // Error tracking is absent in this build; clr_err has no effect.
  logic unused_clr_err;
  assign unused_clr_err = clr_err;

  assign level = '0;
  assign ovf   = 1'b0;
  assign unf   = 1'b0;
`endif

endmodule : enable_stack_array
`default_nettype wire

// File: tb/tb_enable_stack_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_enable_stack_array                                            |
// | Purpose : Self-checking bench for enable_stack_array, NLANES=2, DEPTH=4.   |
// |           Expected outputs come from a behavioural model, queued when an   |
// |           op is driven and compared after the clock edge. Expectations     |
// |           follow ENSTACK_ERR_EN (level/ovf/unf are 0 without it).         |
// | Rev     : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_enable_stack_array;

  localparam int NL = 2;
  localparam int D  = 4;

`ifdef ENSTACK_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] en;
    logic       none_en;
    logic [2:0] level;
    logic       ovf;
    logic       unf;
  } chk_t;

  logic          clk = 1'b0;
  logic          reset, halt, op_valid, clr_err;
  logic [2:0]    op;
  logic [NL-1:0] cond_nz;
  logic [NL-1:0] en;
  logic          none_en;
  logic [2:0]    level;
  logic          ovf, unf;

  int errors = 0;
  int checks = 0;

  chk_t sb[$];
  chk_t e, o;

  // Behavioural model state
  logic [D-1:0] m_stk [NL];
  logic [2:0]   m_lvl;
  logic         m_ovf, m_unf;

  always #5 clk = ~clk;

  enable_stack_array #(
    .NLANES (NL),
    .DEPTH  (D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .halt     (halt),
    .op_valid (op_valid),
    .op       (op),
    .cond_nz  (cond_nz),
    .clr_err  (clr_err),
    .en       (en),
    .none_en  (none_en),
    .level    (level),
    .ovf      (ovf),
    .unf      (unf)
  );

  function automatic chk_t get_obs();
    chk_t r;
    r.en      = en;
    r.none_en = none_en;
    r.level   = level;
    r.ovf     = ovf;
    r.unf     = unf;
    return r;
  endfunction

  function automatic chk_t model_exp();
    chk_t r;
    r.en      = {m_stk[1][0], m_stk[0][0]};
    r.none_en = ~|r.en;
    r.level   = m_lvl;
    r.ovf     = m_ovf;
    r.unf     = m_unf;
    return r;
  endfunction

  // Drive one cycle at the negedge, advance the model, queue its expectation,
  // then return 1 time unit after the capturing posedge.
  task automatic drive(input logic rst_n, input logic hlt, input logic vld,
                       input logic [2:0] o_code, input logic [1:0] c,
                       input logic clr);
    @(negedge clk);
    reset = rst_n; halt = hlt; op_valid = vld; op = o_code;
    cond_nz = c; clr_err = clr;
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) m_stk[i] = '1;
      m_lvl = 3'd0; m_ovf = 1'b0; m_unf = 1'b0;
    end else if (!hlt) begin
      if (ERR && clr) begin
        m_ovf = 1'b0; m_unf = 1'b0;
      end
      if (vld) begin
        case (o_code)
          3'd1: for (int i = 0; i < NL; i++) m_stk[i][0] = 1'b1;
          3'd2: begin
            for (int i = 0; i < NL; i++) m_stk[i] = {m_stk[i][D-2:0], m_stk[i][0]};
            if (ERR) begin
              if (m_lvl == 3'(D)) m_ovf = 1'b1;
              else                m_lvl = m_lvl + 3'd1;
            end
          end
          3'd3: begin
            for (int i = 0; i < NL; i++) m_stk[i] = {m_stk[i][D-1], m_stk[i][D-1:1]};
            if (ERR) begin
              if (m_lvl == 3'd0) m_unf = 1'b1;
              else               m_lvl = m_lvl - 3'd1;
            end
          end
          3'd4: for (int i = 0; i < NL; i++) if (!c[i]) m_stk[i][0] = 1'b0;
          default: ;
        endcase
      end
    end
    sb.push_back(model_exp());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 1'b0);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_model: got %b want %b", o, e); end
    checks++;
    if (o !== chk_t'(8'b11_0_000_00)) begin errors++; $display("FAIL reset_const: got %b want %b", o, 8'b11000000); end
  endtask

  task automatic test_push_jumpf();
    drive(1'b1, 1'b0, 1'b1, 3'd2, 2'b00, 1'b0);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL push1: got %b want %b", o, e); end
    drive(1'b1, 1'b0, 1'b1, 3'd4, 2'b01, 1'b0);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL jumpf01_model: got %b want %b", o, e); end
    checks++;
    if (o !== chk_t'{en:2'b01, none_en:1'b0, level:(ERR ? 3'd1 : 3'd0), ovf:1'b0, unf:1'b0}) begin
      errors++; $display("FAIL jumpf01_const: got %b", o);
    end
  endtask

  task automatic test_pop();
    drive(1'b1, 1'b0, 1'b1, 3'd3, 2'b00, 1'b0);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL pop_model: got %b want %b", o, e); end
    checks++;
    if (o !== chk_t'(8'b11_0_000_00)) begin errors++; $display("FAIL pop_const: got %b want %b", o, 8'b11000000); end
  endtask

  task automatic test_overflow();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 1'b0);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL ovf_reset: got %b want %b", o, e); end
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0, 1'b1, 3'd2, 2'b00, 1'b0);
      e = sb.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL ovf_push%0d: got %b want %b", k, o, e); end
    end
    checks++;
    if (o !== chk_t'{en:2'b11, none_en:1'b0, level:(ERR ? 3'd4 : 3'd0), ovf:ERR, unf:1'b0}) begin
      errors++; $display("FAIL ovf_after5: got %b", o);
    end
    // Clearing together with another overflowing push must leave ovf set.
    drive(1'b1, 1'b0, 1'b1, 3'd2, 2'b00, 1'b1);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL ovf_clr_collide: got %b want %b", o, e); end
    drive(1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 1'b1);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL ovf_clr_model: got %b want %b", o, e); end
    checks++;
    if (o !== chk_t'{en:2'b11, none_en:1'b0, level:(ERR ? 3'd4 : 3'd0), ovf:1'b0, unf:1'b0}) begin
      errors++; $display("FAIL ovf_clr_const: got %b", o);
    end
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 1'b0);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL unf_reset: got %b want %b", o, e); end
    drive(1'b1, 1'b0, 1'b1, 3'd3, 2'b00, 1'b0);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== chk_t'{en:2'b11, none_en:1'b0, level:3'd0, ovf:1'b0, unf:ERR}) begin
      errors++; $display("FAIL unf_pop0: got %b want %b", o, e);
    end
    drive(1'b1, 1'b0, 1'b1, 3'd4, 2'b00, 1'b0);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== e || o.none_en !== 1'b1) begin errors++; $display("FAIL unf_jumpf00: got %b want %b", o, e); end
    drive(1'b1, 1'b0, 1'b1, 3'd1, 2'b00, 1'b0);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== e || o.en !== 2'b11) begin errors++; $display("FAIL unf_allen: got %b want %b", o, e); end
    // Halt must also block clr_err.
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'b00, 1'b1);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== e || o.unf !== ERR) begin errors++; $display("FAIL unf_halt_clr: got %b want %b", o, e); end
  endtask

  task automatic test_halt();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 1'b0);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL halt_reset: got %b want %b", o, e); end
    drive(1'b1, 1'b0, 1'b1, 3'd4, 2'b10, 1'b0);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL halt_pre: got %b want %b", o, e); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 3'd2, 2'b00, 1'b0);
      e = sb.pop_front(); o = get_obs(); checks++;
      if (o !== chk_t'{en:2'b10, none_en:1'b0, level:3'd0, ovf:1'b0, unf:1'b0}) begin
        errors++; $display("FAIL halt_push%0d: got %b want %b", k, o, e);
      end
    end
    drive(1'b0, 1'b1, 1'b1, 3'd2, 2'b00, 1'b1);
    e = sb.pop_front(); o = get_obs(); checks++;
    if (o !== e || o !== chk_t'(8'b11_0_000_00)) begin
      errors++; $display("FAIL halt_reset_push: got %b want %b", o, e);
    end
  endtask

  task automatic test_back_to_back();
    logic rn, h, v, cl;
    logic [2:0] oc;
    logic [1:0] cz;
    for (int k = 0; k < 60; k++) begin
      rn = ($urandom_range(0, 24) != 0);
      h  = ($urandom_range(0, 7) == 0);
      v  = ($urandom_range(0, 5) != 0);
      oc = 3'($urandom_range(0, 7));
      cz = 2'($urandom_range(0, 3));
      cl = ($urandom_range(0, 9) == 0);
      drive(rn, h, v, oc, cz, cl);
      e = sb.pop_front(); o = get_obs(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL b2b[%0d] op=%0d v=%b h=%b: got %b want %b", k, oc, v, h, o, e);
      end
    end
  endtask

  initial begin
    reset = 1'b0; halt = 1'b0; op_valid = 1'b0; op = 3'd0;
    cond_nz = '0; clr_err = 1'b0;
    for (int i = 0; i < NL; i++) m_stk[i] = '1;
    m_lvl = 3'd0; m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_push_jumpf();
    test_pop();
    test_overflow();
    test_underflow();
    test_halt();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_enable_stack_array
`default_nettype wire

// File: doc/enable_stack_array.md
ENABLE_STACK_ARRAY -- requirements
Module: enable_stack_array

Interface
REQ-001 The block SHALL have parameter NLANES, default 2, number of processing-element lanes.
REQ-002 The block SHALL have parameter DEPTH, default 32, enable-stack entries per lane (legal range 2..64).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port halt  input  1  freezes all state while 1.
REQ-006 The block SHALL have port op_valid  input  1  op qualifier.
REQ-007 The block SHALL have port op  input  3  operation: NOP=0, ALLEN=1, PUSHEN=2, POPEN=3, JUMPF=4; 5..7 treated as NOP.
REQ-008 The block SHALL have port cond_nz  input  NLANES  per-lane "d value nonzero" flag, used by JUMPF.
REQ-009 The block SHALL have port clr_err  input  1  clears sticky error flags.
REQ-010 The block SHALL have port en  output  NLANES  current top-of-stack enable per lane.
REQ-011 The block SHALL have port none_en  output  1  high when every en bit is 0.
REQ-012 The block SHALL have port level  output  clog2(DEPTH+1)  pushes outstanding.
REQ-013 The block SHALL have ports ovf, unf  output  1 each  sticky overflow/underflow flags.

Function
REQ-014 An op SHALL take effect only when op_valid=1 and halt=0 on a posedge; results SHALL be visible on en/level one cycle later, with no combinational path from op to en.
REQ-015 Each lane SHALL hold a DEPTH-entry shift stack; entry 0 is the top and drives en[lane].
REQ-016 ALLEN SHALL set entry 0 of every lane to 1 and leave deeper entries and level unchanged.
REQ-017 PUSHEN SHALL shift every lane down one entry, duplicating entry 0 into entry 1 and discarding entry DEPTH-1.
REQ-018 POPEN SHALL shift every lane up one entry, with entry DEPTH-1 keeping its value (bottom replicated).
REQ-019 JUMPF SHALL clear entry 0 of lane i when cond_nz[i]=0 and leave it unchanged otherwise.
REQ-020 On PUSHEN, level SHALL increment, saturating at DEPTH; a PUSHEN at level==DEPTH SHALL still shift and SHALL set ovf.
REQ-021 On POPEN, level SHALL decrement, saturating at 0; a POPEN at level==0 SHALL still shift and SHALL set unf.
REQ-022 ovf and unf SHALL stay set until clr_err=1 or reset; when clr_err coincides with a new error event, the flag SHALL end set.
REQ-023 none_en SHALL be the registered-state NOR of en, valid in the same cycle as en.
REQ-024 While halt=1, all stack entries, level and flags SHALL hold regardless of op_valid and clr_err.

Reset
REQ-025 When reset=0 at a posedge, the block SHALL set every stack entry to 1, en to all-ones, none_en to 0, level to 0, and ovf and unf to 0.
REQ-026 Reset SHALL override halt, op_valid and clr_err in the same cycle; an op presented during reset SHALL be dropped.

Configuration
REQ-027 With ENSTACK_ERR_EN defined, the block SHALL implement level, ovf, unf and clr_err as specified.
REQ-028 Without ENSTACK_ERR_EN, the block SHALL tie level, ovf and unf to 0, SHALL ignore clr_err, SHALL remove the counter logic, and SHALL keep the stack behaviour unchanged.

Structure
REQ-029 Package enstack_pkg SHALL hold the op encoding typedef (enstack_op_t) and the op constants.
REQ-030 Sub-module enstack_lane SHALL implement one lane's DEPTH-entry stack, and the top level SHALL instantiate it NLANES times with a generate loop; the level counter and flags SHALL live in the top level.

Verification
REQ-031 The bench SHALL cover, with NLANES=2 and DEPTH=4: reset, then PUSHEN; JUMPF cond_nz=01 -> en=01, level=1, none_en=0.
REQ-032 The bench SHALL cover: continuing from REQ-031, POPEN -> en=11, level=0, unf=0.
REQ-033 The bench SHALL cover: 5 consecutive PUSHEN from reset -> level=4, ovf=1 after the 5th; clr_err -> ovf=0.
REQ-034 The bench SHALL cover: POPEN at level 0 -> unf=1, en=11 (bottom replicated); JUMPF cond_nz=00 -> none_en=1; ALLEN -> en=11.
REQ-035 The bench SHALL cover: halt=1 while PUSHEN is valid for 3 cycles -> level and en unchanged; reset=0 concurrent with PUSHEN -> level=0, en=11.
REQ-036 The bench SHALL cover: build without ENSTACK_ERR_EN, repeat REQ-033 -> ovf=0 and level=0 throughout, and en matches the build with the macro defined.
